// File: rtl/bin_to_ascii_seq_if.sv
// bin_to_ascii_seq_if: request/result handshake bundle for the binary-to-ASCII converter
interface bin_to_ascii_seq_if #(
  parameter int IN_WIDTH = 32,
  parameter int DIGITS = 10
);
  logic in_valid;
  logic in_ready;
  logic [IN_WIDTH-1:0] in_data;
  logic signed_mode;
  logic blank_zeros;
  logic out_valid;
  logic out_ready;
  logic [DIGITS*8-1:0] lcd_out;
  logic overflow;
  modport master (
    output in_valid, in_data, signed_mode, blank_zeros, out_ready,
    input in_ready, out_valid, lcd_out, overflow
  );
  modport slave (
    input in_valid, in_data, signed_mode, blank_zeros, out_ready,
    output in_ready, out_valid, lcd_out, overflow
  );
endinterface

// File: rtl/bin_to_ascii_seq.sv
// bin_to_ascii_seq: iterative double-dabble binary to decimal ASCII converter with sign, blanking and overflow
module bin_to_ascii_seq #(
  parameter int IN_WIDTH = 32,
  parameter int DIGITS = 10
) (
  input logic clk,
  input logic nRst,
  bin_to_ascii_seq_if.slave bus
);
  localparam int BW = DIGITS * 4;
  localparam int CW = $clog2(IN_WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, FORMAT, DONE} state_t;
  state_t state;
  logic [IN_WIDTH-1:0] mag;
  logic [BW-1:0] bcd, bcd_adj;
  logic [CW-1:0] cnt;
  logic [DIGITS*8-1:0] lcd, fmt;
  logic carry, neg, sm, bz, rdy, vld, ovf, fmt_ovf;
  assign bus.in_ready = rdy;
  assign bus.out_valid = vld;
  assign bus.lcd_out = lcd;
  assign bus.overflow = ovf;
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      bcd_adj[i*4+:4] = bcd[i*4+:4] >= 4'd5 ? bcd[i*4+:4] + 4'd3 : bcd[i*4+:4];
  end
  // The sign slot never breaks a run of leading zeros; the units digit is never blanked.
  always_comb begin
    logic lead;
    logic [3:0] nib;
    fmt = '0;
    lead = bz;
    nib = '0;
    fmt_ovf = carry | (sm & (|bcd[BW-1-:4]));
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = bcd[i*4+:4];
      if (sm && i == DIGITS - 1)
        fmt[i*8+:8] = neg ? 8'h2D : 8'h20;
      else begin
        lead = lead && nib == 4'd0 && i != 0;
        fmt[i*8+:8] = lead ? 8'h20 : {4'h3, nib};
      end
    end
    if (fmt_ovf)
      fmt = {DIGITS{8'h5F}};
  end
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state <= IDLE;
      mag <= '0;
      bcd <= '0;
      cnt <= '0;
      carry <= 1'b0;
      neg <= 1'b0;
      sm <= 1'b0;
      bz <= 1'b0;
      rdy <= 1'b1;
      vld <= 1'b0;
      ovf <= 1'b0;
      lcd <= {DIGITS{8'h20}};
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          sm <= bus.signed_mode;
          bz <= bus.blank_zeros;
          neg <= bus.signed_mode & bus.in_data[IN_WIDTH-1];
          mag <= (bus.signed_mode & bus.in_data[IN_WIDTH-1]) ? -bus.in_data : bus.in_data;
          bcd <= '0;
          carry <= 1'b0;
          cnt <= CW'(IN_WIDTH - 1);
          rdy <= 1'b0;
          state <= SHIFT;
        end
        SHIFT: begin
          {bcd, mag} <= {bcd_adj[BW-2:0], mag, 1'b0};
          carry <= carry | bcd_adj[BW-1];
          cnt <= cnt - 1'b1;
          if (cnt == '0)
            state <= FORMAT;
        end
        FORMAT: begin
          lcd <= fmt;
          ovf <= fmt_ovf;
          vld <= 1'b1;
          state <= DONE;
        end
        DONE: if (bus.out_ready) begin
          vld <= 1'b0;
          rdy <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/bin_to_ascii_seq.md
# bin_to_ascii_seq

Sequential, parametrised binary-to-decimal-ASCII converter for driving the LCD character path. It accepts an IN_WIDTH-bit value over a valid/ready handshake and runs iterative double-dabble, one input bit per cycle. It emits DIGITS ASCII characters with optional signed interpretation, leading-zero blanking and overflow indication, and holds the result under output backpressure. It sits between the datapath result registers and the LCD character writer.

## Interface
- IN_WIDTH, 32: input value width in bits (≥ 4).
- DIGITS, 10: number of output characters (≥ 2); the BCD register is DIGITS*4 bits.
- clk  input  1  system clock, rising edge.
- nRst  input  1  asynchronous active-low reset.
- in_valid  input  1  request carries a value to convert.
- in_ready  output  1  block can accept a request; high only in IDLE.
- in_data  input  IN_WIDTH  binary value.
- signed_mode  input  1  treat in_data as two's complement; sampled on accept.
- blank_zeros  input  1  replace leading zeros with spaces; sampled on accept.
- out_valid  output  1  lcd_out and overflow hold a completed result.
- out_ready  input  1  consumer takes the result.
- lcd_out  output  DIGITS*8  ASCII characters; [DIGITS*8-1 -: 8] is leftmost (most significant).
- overflow  output  1  the value did not fit; lcd_out is all underscores.

## Operation
- States: IDLE, SHIFT, FORMAT, DONE.
- IDLE: in_ready=1. If in_valid=1 at a rising edge, the block accepts:
  - latches the mode bits;
  - latches the magnitude: if signed_mode and in_data MSB is 1, magnitude = (~in_data + 1) taken as unsigned IN_WIDTH bits (the most negative value gives 2^(IN_WIDTH-1)); otherwise magnitude = in_data;
  - sets neg = signed_mode & MSB;
  - clears the BCD register and the carry flag;
  - loads bit counter = IN_WIDTH-1 and goes to SHIFT.
- SHIFT, one input bit per cycle:
  - add 3 to every BCD nibble ≥ 5;
  - shift {BCD, magnitude} left by 1;
  - OR the bit shifted out of the BCD MSB into a sticky carry flag.
  - After IN_WIDTH shifts, go to FORMAT.
- FORMAT, single cycle, registers lcd_out and overflow, then goes to DONE:
  - Digit chars are 0x30+nibble.
  - Signed overflow: if signed_mode=1, the leftmost position is the sign position. It is 0x2D when neg, else 0x20. Overflow if the carry flag is set or the top nibble ≠ 0.
  - Unsigned overflow: if signed_mode=0, all DIGITS positions are digits. Overflow if the carry flag is set.
  - Blanking: if blank_zeros=1, every leading zero digit becomes 0x20. The least significant digit is never blanked, so zero displays as "0". With signed_mode=1 the sign stays at the leftmost position.
  - On overflow: every character = 0x5F and overflow=1; otherwise overflow=0.
- DONE: out_valid=1; lcd_out and overflow are stable. If out_ready=1 at an edge, go to IDLE. in_ready=0 throughout DONE; the accept and the release never share an edge.
- in_valid outside IDLE is ignored; in_data/mode changes after accept have no effect.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, overflow=0, lcd_out all 0x20. Internal registers are cleared.
- Asserting nRst at any point, including mid-SHIFT or in DONE, aborts the conversion immediately and asynchronously. No result is emitted after release.
- Latency: accept at edge E0; the shifts occur at edges E1..E_IN_WIDTH; FORMAT registers at E_IN_WIDTH+1. out_valid is high from E_IN_WIDTH+1.
- Release: out_ready=1 at edge Er gives out_valid=0 and in_ready=1 after Er. The earliest next accept is Er+1.
- Minimum period per conversion: IN_WIDTH+3 cycles with out_ready held high.
- lcd_out is registered and changes only at the FORMAT edge or on reset. It keeps its last value after release until the next FORMAT.

## Test plan
Benches use IN_WIDTH=16, DIGITS=5 unless stated otherwise.
- Basic decimal conversion: in_data=0x04D2, both modes 0 -> out_valid rises 17 edges after accept, lcd_out=30 31 32 33 34, overflow=0.
- Leading-zero blanking: blank_zeros=1 with 1234 -> 20 31 32 33 34; blank_zeros=1 with 0 -> 20 20 20 20 30.
- Unsigned full range: 65535, signed_mode=0 -> 36 35 35 33 35, overflow=0. With DIGITS=4, 10000 -> 5F×4, overflow=1.
- Signed conversion and signed overflow: signed_mode=1, blank_zeros=1, 0xFFFF -> 2D 20 20 20 31. With signed_mode=1, 0x8000 (magnitude 32768 needs 5 digits) -> 5F×5, overflow=1.
- Output backpressure: hold out_ready=0 for 10 cycles after out_valid while pulsing in_valid with a new value -> lcd_out unchanged, in_ready=0, request ignored. Then out_ready=1 for one edge -> out_valid=0 and in_ready=1 on the next cycle; the next accept converts the new value.
- Reset mid-operation: assert nRst 5 cycles into SHIFT -> immediately in_ready=1, out_valid=0, lcd_out all 0x20. A subsequent conversion of 42 gives 30 30 30 34 32.
